fetch_sequencer: RTL and testbench

Front-end controller for the pipelined RAT core's fetch stage. Owns the program counter and drives the fetch pipeline register's hold and bubble controls. It arbitrates between sequential fetch, decode hazard stalls, execute-stage branch redirects and (optionally) interrupt entry. Sits between instruction memory, the fetch register and the decode/execute hazard logic.

---
 rtl/rat_pipe_pkg.sv | 25 ++
 rtl/fetch_seq_bubble_cnt.sv | 49 ++++
 rtl/fetch_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rat_pipe_pkg.sv
// -----------------------------------------------------------------------------
// rat_pipe_pkg
//   Shared constants and types for the RAT core pipeline front end.
//   - ADDR_W / INSTR_W : program counter and instruction widths
//   - NOP              : instruction encoding loaded into a flushed fetch register
//   - INTR_VEC         : default interrupt vector address
//   - fetch_seq_state_t: fetch sequencer FSM states (fixed legacy encoding)
// -----------------------------------------------------------------------------
package rat_pipe_pkg;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned INSTR_W = 18;

  localparam logic [INSTR_W-1:0] NOP      = '0;
  localparam logic [ADDR_W-1:0]  INTR_VEC = 10'h3FF;

  // Explicit encodings keep the state register compatible with older
  // decoders that compare against raw 2-bit codes.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_seq_state_t;

endpackage : rat_pipe_pkg

// File: rtl/fetch_seq_bubble_cnt.sv
// -----------------------------------------------------------------------------
// fetch_seq_bubble_cnt
//   2-bit loadable down-counter that tracks the redirect bubbles still owed
//   after a branch or interrupt redirect.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset (count clears to 0)
//     load         : load load_val (takes priority over everything else)
//     load_val[1:0]: reload value
//     dec          : decrement request
//     freeze       : hold the count even when dec is high (hazard stall)
//     tc           : terminal count, high while the count equals 1
// -----------------------------------------------------------------------------
module fetch_seq_bubble_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [1:0] load_val,
  input  logic       dec,
  input  logic       freeze,
  output logic       tc
);

  logic [1:0] cnt_d;
  logic [1:0] cnt_q;

  always_comb begin
    // NOTE: assigning a default first guarantees every path drives cnt_d,
    // so no latch can be inferred regardless of which branch is taken.
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && !freeze && (cnt_q != 2'd0)) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // the pre-edge value of every other flop, independent of block order.
    if (!rst_n) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == 2'd1);

endmodule : fetch_seq_bubble_cnt

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Fetch-stage front-end controller: owns the program counter and drives the
//   fetch register hold (fetch_stall) and bubble (fetch_flush) controls.
//   Arbitrates between sequential fetch, decode hazard stalls, execute-stage
//   branch redirects and, optionally, interrupt entry.
//
//   Build option: define FETCH_SEQ_INTR_EN to include the interrupt path.
//   Without it intr_req is ignored and intr_ack / saved_pc are tied to zero.
//
//   Parameters:
//     ADDR_W           : PC width
//     RESET_PC         : PC loaded on reset
//     INTR_VEC         : interrupt vector address
//     REDIRECT_BUBBLES : bubbles per redirect including the redirect cycle (1..3)
//   Ports:
//     clk, rst_n    : clock, asynchronous active-low reset
//     hazard_stall  : decode load-use hazard, hold the fetch register
//     branch_taken  : execute-stage redirect strobe, branch_target valid with it
//     intr_req      : level interrupt request (already masked)
//     pc            : registered instruction memory address
//     fetch_stall   : fetch register hold enable
//     fetch_flush   : fetch register loads NOP instead of memory data
//     intr_ack      : one-cycle pulse when an interrupt is taken
//     saved_pc      : registered return address captured at interrupt entry
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int unsigned        ADDR_W           = rat_pipe_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC         = '0,
  parameter logic [ADDR_W-1:0]  INTR_VEC         = ADDR_W'(rat_pipe_pkg::INTR_VEC),
  parameter int unsigned        REDIRECT_BUBBLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hazard_stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              intr_req,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_stall,
  output logic              fetch_flush,
  output logic              intr_ack,
  output logic [ADDR_W-1:0] saved_pc
);

  import rat_pipe_pkg::*;

  // With a single bubble the redirect cycle itself is the only bubble, so the
  // FSM never enters DRAIN. Otherwise DRAIN covers the remaining bubbles.
  localparam bit         USE_DRAIN = (REDIRECT_BUBBLES > 1);
  localparam logic [1:0] RELOAD    = 2'(REDIRECT_BUBBLES - 1);

  fetch_seq_state_t  state_d, state_q;
  logic [ADDR_W-1:0] pc_d, pc_q;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_tc;

`ifdef FETCH_SEQ_INTR_EN
  logic              intr_take;
  logic [ADDR_W-1:0] saved_pc_d, saved_pc_q;
`endif

  fetch_seq_bubble_cnt u_bubble_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (RELOAD),
    .dec      (cnt_dec),
    .freeze   (hazard_stall),
    .tc       (cnt_tc)
  );

  // ---------------------------------------------------------------------------
  // Next-state / next-PC logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_stall = 1'b0;
    fetch_flush = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
`ifdef FETCH_SEQ_INTR_EN
    intr_take   = 1'b0;
    saved_pc_d  = saved_pc_q;
`endif

    unique case (state_q)
      // The fetch register is loaded with a bubble while pc settles at RESET_PC.
      BOOT: begin
        fetch_flush = 1'b1;
        state_d     = RUN;
      end

      RUN: begin
        if (branch_taken) begin
          // A redirect overrides a hazard: the instruction being held is on
          // the wrong path anyway.
          pc_d        = branch_target;
          fetch_flush = 1'b1;
          if (USE_DRAIN) begin
            cnt_load = 1'b1;
            state_d  = DRAIN;
          end
        end
`ifdef FETCH_SEQ_INTR_EN
        // Interrupts wait for a hazard to clear so the return address points
        // at an instruction that has not yet been consumed by decode.
        else if (intr_req && !hazard_stall) begin
          intr_take   = 1'b1;
          saved_pc_d  = pc_q;
          pc_d        = INTR_VEC;
          fetch_flush = 1'b1;
          if (USE_DRAIN) begin
            cnt_load = 1'b1;
            state_d  = DRAIN;
          end
        end
`endif
        else if (hazard_stall) begin
          fetch_stall = 1'b1;
        end else begin
          pc_d = pc_q + ADDR_W'(1);
        end
      end

      DRAIN: begin
        if (branch_taken) begin
          // Newest redirect wins and restarts the bubble count.
          pc_d        = branch_target;
          fetch_flush = 1'b1;
          cnt_load    = 1'b1;
        end else if (hazard_stall) begin
          // Counter freezes via its freeze input; stall and flush stay exclusive.
          fetch_stall = 1'b1;
        end else begin
          fetch_flush = 1'b1;
          cnt_dec     = 1'b1;
          if (cnt_tc) begin
            state_d = RUN;
          end
        end
      end

      default: begin
        state_d     = BOOT;
        fetch_flush = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and PC registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc = pc_q;

`ifdef FETCH_SEQ_INTR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saved_pc_q <= '0;
    end else begin
      saved_pc_q <= saved_pc_d;
    end
  end

  assign intr_ack = intr_take;
  assign saved_pc = saved_pc_q;
`else
  logic intr_req_unused;
  assign intr_req_unused = intr_req;
  assign intr_ack        = 1'b0;
  assign saved_pc        = '0;
`endif

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Directed self-checking bench for fetch_sequencer with REDIRECT_BUBBLES=2,
//   RESET_PC=0, INTR_VEC=0x3FF. Interrupt steps are compiled only when
//   FETCH_SEQ_INTR_EN is defined; otherwise intr_req is checked to be ignored.
//   Inputs change 1 time unit after a rising edge; combinational outputs are
//   sampled 1 unit later, pc right after the following edge.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam int unsigned AW = 10;

  logic          clk;
  logic          rst_n;
  logic          hazard_stall;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic          intr_req;
  logic [AW-1:0] pc;
  logic          fetch_stall;
  logic          fetch_flush;
  logic          intr_ack;
  logic [AW-1:0] saved_pc;

  int checks   = 0;
  int failures = 0;

  fetch_sequencer #(
    .ADDR_W           (AW),
    .RESET_PC         (10'h000),
    .INTR_VEC         (10'h3FF),
    .REDIRECT_BUBBLES (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hazard_stall  (hazard_stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .intr_req      (intr_req),
    .pc            (pc),
    .fetch_stall   (fetch_stall),
    .fetch_flush   (fetch_flush),
    .intr_ack      (intr_ack),
    .saved_pc      (saved_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle branch; returns just after the redirect edge (in DRAIN).
  task automatic redirect(input logic [AW-1:0] tgt);
    branch_taken  = 1'b1;
    branch_target = tgt;
    #1;
    step();
    branch_taken  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    hazard_stall  = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    intr_req      = 1'b0;
    step();
    step();

    // Reset state
    check("rst_pc",       32'(pc),          32'h000);
    check("rst_flush",    32'(fetch_flush), 32'd1);
    check("rst_stall",    32'(fetch_stall), 32'd0);
    check("rst_ack",      32'(intr_ack),    32'd0);
    check("rst_saved_pc", 32'(saved_pc),    32'h000);

    // Reset release: BOOT cycle, then 0x000, 0x001, 0x002
    rst_n = 1'b1;
    #1;
    check("boot_flush", 32'(fetch_flush), 32'd1);
    check("boot_stall", 32'(fetch_stall), 32'd0);
    step();
    check("boot_pc_held", 32'(pc), 32'h000);
    check("run_no_flush", 32'(fetch_flush), 32'd0);
    step();
    check("seq_pc_1", 32'(pc), 32'h001);
    step();
    check("seq_pc_2", 32'(pc), 32'h002);

    // Hazard stall for 3 cycles at pc=0x010
    redirect(10'h010);
    step();
    check("hz_setup_pc", 32'(pc), 32'h010);
    for (int i = 0; i < 3; i++) begin
      hazard_stall = 1'b1;
      #1;
      check("hz_stall", 32'(fetch_stall), 32'd1);
      check("hz_no_flush", 32'(fetch_flush), 32'd0);
      step();
      check("hz_pc_held", 32'(pc), 32'h010);
    end
    hazard_stall = 1'b0;
    #1;
    check("hz_released", 32'(fetch_stall), 32'd0);
    step();
    check("hz_pc_inc", 32'(pc), 32'h011);

    // Branch with simultaneous hazard at pc=0x040 -> 0x120, two bubbles
    redirect(10'h040);
    step();
    check("br_setup_pc", 32'(pc), 32'h040);
    branch_taken  = 1'b1;
    branch_target = 10'h120;
    hazard_stall  = 1'b1;
    #1;
    check("br_hz_stall", 32'(fetch_stall), 32'd0);
    check("br_hz_flush", 32'(fetch_flush), 32'd1);
    step();
    branch_taken = 1'b0;
    hazard_stall = 1'b0;
    check("br_pc_target", 32'(pc), 32'h120);
    #1;
    check("br_drain_flush", 32'(fetch_flush), 32'd1);
    step();
    check("br_pc_held", 32'(pc), 32'h120);
    #1;
    check("br_run_flush", 32'(fetch_flush), 32'd0);
    step();
    check("br_pc_inc", 32'(pc), 32'h121);

    // Second branch during DRAIN reloads the counter
    redirect(10'h180);
    check("rl_first_pc", 32'(pc), 32'h180);
    branch_taken  = 1'b1;
    branch_target = 10'h200;
    #1;
    check("rl_flush", 32'(fetch_flush), 32'd1);
    step();
    branch_taken = 1'b0;
    check("rl_pc_target", 32'(pc), 32'h200);
    #1;
    check("rl_still_drain", 32'(fetch_flush), 32'd1);
    step();
    check("rl_pc_held", 32'(pc), 32'h200);
    #1;
    check("rl_run_flush", 32'(fetch_flush), 32'd0);
    step();
    check("rl_pc_inc", 32'(pc), 32'h201);

    // Hazard during DRAIN freezes the bubble count
    redirect(10'h300);
    hazard_stall = 1'b1;
    #1;
    check("dz_stall", 32'(fetch_stall), 32'd1);
    check("dz_no_flush", 32'(fetch_flush), 32'd0);
    step();
    hazard_stall = 1'b0;
    check("dz_pc_held", 32'(pc), 32'h300);
    #1;
    check("dz_frozen_flush", 32'(fetch_flush), 32'd1);
    step();
    check("dz_pc_held2", 32'(pc), 32'h300);
    #1;
    check("dz_run_flush", 32'(fetch_flush), 32'd0);
    step();
    check("dz_pc_inc", 32'(pc), 32'h301);

    // PC wrap 0x3FE -> 0x3FF -> 0x000
    redirect(10'h3FE);
    step();
    check("wr_pc_3fe", 32'(pc), 32'h3FE);
    #1;
    check("wr_stall_a", 32'(fetch_stall), 32'd0);
    check("wr_flush_a", 32'(fetch_flush), 32'd0);
    step();
    check("wr_pc_3ff", 32'(pc), 32'h3FF);
    check("wr_stall_b", 32'(fetch_stall), 32'd0);
    check("wr_flush_b", 32'(fetch_flush), 32'd0);
    step();
    check("wr_pc_000", 32'(pc), 32'h000);

`ifdef FETCH_SEQ_INTR_EN
    // Interrupt at pc=0x055
    redirect(10'h055);
    step();
    check("in_setup_pc", 32'(pc), 32'h055);
    intr_req = 1'b1;
    #1;
    check("in_ack", 32'(intr_ack), 32'd1);
    check("in_flush", 32'(fetch_flush), 32'd1);
    step();
    check("in_pc_vec", 32'(pc), 32'h3FF);
    check("in_saved_pc", 32'(saved_pc), 32'h055);
    check("in_ack_drain", 32'(intr_ack), 32'd0);
    intr_req = 1'b0;
    step();
    check("in_pc_held", 32'(pc), 32'h3FF);
    step();
    check("in_pc_wrap", 32'(pc), 32'h000);

    // Interrupt deferred behind a hazard stall
    hazard_stall = 1'b1;
    intr_req     = 1'b1;
    #1;
    check("id_no_ack", 32'(intr_ack), 32'd0);
    check("id_stall", 32'(fetch_stall), 32'd1);
    step();
    hazard_stall = 1'b0;
    #1;
    check("id_ack", 32'(intr_ack), 32'd1);
    step();
    intr_req = 1'b0;
    check("id_pc_vec", 32'(pc), 32'h3FF);
    check("id_saved_pc", 32'(saved_pc), 32'h000);
`else
    // Interrupt path compiled out: intr_req has no effect
    check("ni_setup_pc", 32'(pc), 32'h000);
    intr_req = 1'b1;
    #1;
    check("ni_no_ack", 32'(intr_ack), 32'd0);
    check("ni_no_flush", 32'(fetch_flush), 32'd0);
    step();
    intr_req = 1'b0;
    check("ni_pc_inc", 32'(pc), 32'h001);
    check("ni_saved_pc", 32'(saved_pc), 32'h000);
`endif

    // Reset pulsed mid-DRAIN: back to BOOT, pending redirect discarded
    redirect(10'h123);
    #1;
    check("rd_in_drain", 32'(fetch_flush), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rd_pc_reset", 32'(pc), 32'h000);
    check("rd_flush", 32'(fetch_flush), 32'd1);
    check("rd_saved_pc", 32'(saved_pc), 32'h000);
    step();
    rst_n = 1'b1;
    #1;
    check("rd_boot_flush", 32'(fetch_flush), 32'd1);
    step();
    check("rd_boot_pc", 32'(pc), 32'h000);
    #1;
    check("rd_run_flush", 32'(fetch_flush), 32'd0);
    step();
    check("rd_pc_inc", 32'(pc), 32'h001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_sequencer
